// File: rtl/p_s_converter.sv
// Parallel-to-serial converter: accepts a C_BITS_IN-bit word on a LOAD/READY
// handshake and shifts it out MSB first, one bit per CK. Back-to-back words
// stream with no idle cycle so the receiver stays word-aligned.
// Optional feature: define P_S_PARITY_EN to append an even-parity bit to each
// frame (frame length becomes C_BITS_IN+1).
module p_s_converter #(
    parameter int C_BITS_IN = 255
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic [C_BITS_IN-1:0] D,
    input  logic                 LOAD,
    output logic                 READY,
    output logic                 Q,
    output logic                 FRAME,
    output logic                 LAST
);

    localparam int CW = $clog2(C_BITS_IN + 1);

`ifdef P_S_PARITY_EN
    // The parity bit occupies the slot after D[0], so the frame ends one count later.
    localparam logic [CW-1:0] FINAL   = CW'(C_BITS_IN);
    localparam logic [CW-1:0] PAR_IDX = CW'(C_BITS_IN);
`else
    localparam logic [CW-1:0] FINAL   = CW'(C_BITS_IN - 1);
`endif

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [C_BITS_IN-1:0] sreg_q, sreg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        cnt_inc;
    logic                 q_q, q_d;
    logic                 frame_q, frame_d;
    logic                 last_q, last_d;
`ifdef P_S_PARITY_EN
    logic                 par_q, par_d;
`endif

    // A new word can be taken when idle or while the final bit of a frame is on Q.
    assign READY = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == FINAL));

    assign cnt_inc = cnt_q + CW'(1);

    // Next-state logic: load has priority over shifting; loads outside READY are dropped.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        frame_d = frame_q;
        last_d  = last_q;
`ifdef P_S_PARITY_EN
        par_d   = par_q;
`endif
        if (LOAD && READY) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sreg_d  = {D[C_BITS_IN-2:0], 1'b0};
            q_d     = D[C_BITS_IN-1];
            frame_d = 1'b1;
            last_d  = 1'b0;
`ifdef P_S_PARITY_EN
            par_d   = ^D;
`endif
        end else if (state_q == SHIFT) begin
            if (cnt_q == FINAL) begin
                // Frame complete with no follow-on word: return to idle with a quiet line.
                state_d = IDLE;
                cnt_d   = '0;
                sreg_d  = '0;
                q_d     = 1'b0;
                frame_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                cnt_d   = cnt_inc;
                sreg_d  = {sreg_q[C_BITS_IN-2:0], 1'b0};
                q_d     = sreg_q[C_BITS_IN-1];
`ifdef P_S_PARITY_EN
                if (cnt_inc == PAR_IDX) begin
                    q_d = par_q;
                end
`endif
                last_d  = (cnt_inc == FINAL);
            end
        end
    end

    // State register; synchronous reset abandons any word in flight.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            frame_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef P_S_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            frame_q <= frame_d;
            last_q  <= last_d;
`ifdef P_S_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign Q     = q_q;
    assign FRAME = frame_q;
    assign LAST  = last_q;

endmodule

// File: tb/tb_p_s_converter.sv
// Directed bench for p_s_converter at C_BITS_IN=8. Each row drives inputs for
// one clock edge and lists the outputs expected just after that edge.
module tb_p_s_converter;

    localparam int W = 8;

    logic         CK;
    logic         RST;
    logic [W-1:0] D;
    logic         LOAD;
    logic         READY;
    logic         Q;
    logic         FRAME;
    logic         LAST;

    int total;
    int bad;

    typedef struct {
        logic         rst;
        logic         load;
        logic [W-1:0] d;
        logic         q;
        logic         frame;
        logic         last;
        logic         ready;
    } vec_t;

    vec_t tv[$];

    p_s_converter #(.C_BITS_IN(W)) dut (
        .CK    (CK),
        .RST   (RST),
        .D     (D),
        .LOAD  (LOAD),
        .READY (READY),
        .Q     (Q),
        .FRAME (FRAME),
        .LAST  (LAST)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Drive inputs, take one edge, settle just past it.
    task automatic cyc(input logic rst, input logic load, input logic [W-1:0] d);
        RST  = rst;
        LOAD = load;
        D    = d;
        @(posedge CK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic q, input logic frame,
                           input logic last, input logic ready);
        chk({tag, ".Q"},     Q,     q);
        chk({tag, ".FRAME"}, FRAME, frame);
        chk({tag, ".LAST"},  LAST,  last);
        chk({tag, ".READY"}, READY, ready);
    endtask

    function automatic void add(input logic rst, input logic load, input logic [W-1:0] d,
                                input logic q, input logic frame, input logic last,
                                input logic ready);
        tv.push_back('{rst, load, d, q, frame, last, ready});
    endfunction

    initial begin
        logic [W-1:0] w;
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        LOAD  = 1'b0;
        D     = '0;

`ifndef P_S_PARITY_EN
        // Reset with LOAD high: nothing starts.
        add(1, 1, 8'hFF, 0, 0, 0, 1);
        add(1, 1, 8'hFF, 0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1);

        // Single word 0xA5 from idle.
        add(0, 1, 8'hA5, 1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 1, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1);

        // Streaming 0xC3 then 0x3C with LOAD held.
        add(0, 1, 8'hC3, 1, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 1, 0, 0);
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 1, 1, 1);
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 1, 0, 0);
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 0, 1, 1, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1);

        // 0xFF frame with mid-frame LOAD of 0x00 ignored.
        add(0, 1, 8'hFF, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 1, 8'h00, 1, 1, 0, 0);
        add(0, 1, 8'h00, 1, 1, 1, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1);

        foreach (tv[i]) begin
            cyc(tv[i].rst, tv[i].load, tv[i].d);
            chk_all($sformatf("vec%0d", i), tv[i].q, tv[i].frame, tv[i].last, tv[i].ready);
        end

        // Reset in the middle of an 0x81 frame, then a clean 0x01 frame.
        w = 8'h81;
        cyc(0, 1, w);
        chk_all("rst81.b0", w[7], 1, 0, 0);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 0, 8'h00);
            chk_all($sformatf("rst81.b%0d", i), w[7-i], 1, 0, 0);
        end
        cyc(1, 0, 8'h00);
        chk_all("rst81.abort", 0, 0, 0, 1);
        cyc(0, 0, 8'h00);
        chk_all("rst81.idle", 0, 0, 0, 1);
        w = 8'h01;
        cyc(0, 1, w);
        chk_all("w01.b0", w[7], 1, 0, 0);
        for (int i = 1; i < W; i++) begin
            cyc(0, 0, 8'h00);
            chk_all($sformatf("w01.b%0d", i), w[7-i], 1, (i == W-1), (i == W-1));
        end
        cyc(0, 0, 8'h00);
        chk_all("w01.idle", 0, 0, 0, 1);
`else
        // Parity build: 0x07 gives data 00000111 followed by parity 1.
        cyc(1, 0, 8'h00);
        chk_all("par.rst", 0, 0, 0, 1);
        w = 8'h07;
        cyc(0, 1, w);
        chk_all("par.b0", w[7], 1, 0, 0);
        for (int i = 1; i < W; i++) begin
            cyc(0, 1, 8'h00);
            chk_all($sformatf("par.b%0d", i), w[7-i], 1, 0, 0);
        end
        cyc(0, 0, 8'h00);
        chk_all("par.parity", 1, 1, 1, 1);
        cyc(0, 0, 8'h00);
        chk_all("par.idle", 0, 0, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
